// File: rtl/instr_dec_mc.sv
// Multi-cycle, multi-channel instruction decoder for the fixed-point stack processor.
// Define DEC_ILLEGAL_TRAP_EN to add the sticky ill_op output for illegal decodes.
module instr_dec_mc #(
  parameter int NBDATA = 32,
  parameter int NBOPCO = 6,
  parameter int NBOPER = 9,
  parameter int MDATAW = 8,
  parameter int NUMIN  = 2,
  parameter int NUMOUT = 2,
  parameter int DIVLAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NBOPCO-1:0]        opcode,
  input  logic [NBOPER-1:0]        operand,
  output logic                     stall,
  output logic                     dsp_push,
  output logic                     dsp_pop,
  output logic [3:0]               ula_op,
  output logic [NBDATA-1:0]        ula_data,
  output logic                     mem_wr,
  output logic [MDATAW-1:0]        mem_addr,
  input  logic [NBDATA-1:0]        mem_data_in,
  input  logic [NUMIN*NBDATA-1:0]  io_in,
  input  logic [NUMIN-1:0]         io_vld,
  output logic [NUMIN-1:0]         req_in,
  output logic [NUMOUT-1:0]        out_en,
  output logic                     srf,
  output logic                     neg
`ifdef DEC_ILLEGAL_TRAP_EN
  ,
  output logic                     ill_op
`endif
);

  localparam int CIW = (NUMIN > 1) ? $clog2(NUMIN) : 1;
  localparam int COW = (NUMOUT > 1) ? $clog2(NUMOUT) : 1;
  localparam int CW  = (DIVLAT > 2) ? $clog2(DIVLAT - 1) : 1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_WAIT_IN  = 2'd1;
  localparam logic [1:0] ST_WAIT_ALU = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        ula_op_q, ula_op_d;
  logic [NUMIN-1:0]  req_in_q, req_in_d;
  logic [NUMOUT-1:0] out_en_q, out_en_d;
  logic              srf_q, srf_d;
  logic [CIW-1:0]    ch_q, ch_d;

  logic [7:0]        op8;
  logic [CIW-1:0]    chIn;
  logic [COW-1:0]    chOut;
  logic              inOk, outOk, accept;
  logic              opLegal, opPop, opPush, opWr, opNeg, opSrf, opIn, opOut, opDiv;
  logic [3:0]        opUla;
  logic [NBDATA-1:0] inData;
  logic              unusedOpBits;

  assign op8          = 8'(opcode);
  assign chIn         = operand[CIW-1:0];
  assign chOut        = operand[COW-1:0];
  assign inOk         = int'(chIn) < NUMIN;
  assign outOk        = int'(chOut) < NUMOUT;
  assign accept       = en && (state_q == ST_RUN) && !rst;
  assign unusedOpBits = ^operand;

  always_comb begin
    opLegal = 1'b1;
    opPop   = 1'b0;
    opPush  = 1'b0;
    opWr    = 1'b0;
    opNeg   = 1'b0;
    opSrf   = 1'b0;
    opIn    = 1'b0;
    opOut   = 1'b0;
    opDiv   = 1'b0;
    opUla   = 4'd0;
    case (op8) inside
      8'd0:           opUla = 4'd1;
      8'd1:           begin opWr = 1'b1; opPush = 1'b1; opUla = 4'd1; end
      8'd2:           opWr = 1'b1;
      8'd3:           begin opWr = 1'b1; opPop = 1'b1; opUla = 4'd1; end
      8'd4:           begin opWr = 1'b1; opPush = 1'b1; end
      8'd9:           begin opPop = 1'b1; opSrf = 1'b1; end
      8'd10:          begin opIn = 1'b1; opLegal = inOk; end
      8'd11:          begin opOut = 1'b1; opPop = 1'b1; opLegal = outOk; end
      [8'd14:8'd15]:  opUla = 4'd2;
      [8'd16:8'd17]:  opUla = 4'd3;
      [8'd18:8'd19]:  begin opUla = 4'd4; opDiv = 1'b1; end
      [8'd20:8'd21]:  begin opUla = 4'd5; opDiv = 1'b1; end
      [8'd22:8'd25]:  opUla = 4'd10;
      [8'd26:8'd29]:  opUla = 4'd12;
      [8'd30:8'd31]:  opUla = 4'd11;
      8'd36:          opUla = 4'd9;
      [8'd38:8'd39]:  opUla = 4'd15;
      [8'd40:8'd41]:  opUla = 4'd14;
      [8'd42:8'd43]:  opUla = 4'd13;
      [8'd44:8'd45]:  opUla = 4'd7;
      [8'd46:8'd47]:  opUla = 4'd6;
      [8'd48:8'd49]:  opUla = 4'd8;
      8'd50:          begin opWr = 1'b1; opNeg = 1'b1; end
      8'd51:          begin opWr = 1'b1; opPop = 1'b1; opNeg = 1'b1; end
      default:        opLegal = 1'b0;
    endcase
    // Binary ALU ops consume the second stack operand on their odd encodings
    if (op8 >= 8'd15 && op8 <= 8'd49 && op8[0] && !(op8 >= 8'd33 && op8 <= 8'd37))
      opPop = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ula_op_d = 4'd0;
    req_in_d = '0;
    out_en_d = '0;
    srf_d    = 1'b0;
    ch_d     = ch_q;
    dsp_pop  = 1'b0;
    dsp_push = 1'b0;
    mem_wr   = 1'b0;
    neg      = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) ch_d = chIn;
        if (accept && opLegal) begin
          mem_wr   = opWr;
          dsp_push = opPush;
          dsp_pop  = opPop;
          neg      = opNeg;
          srf_d    = opSrf;
          ula_op_d = opUla;
          if (opOut) out_en_d = NUMOUT'(1) << chOut;
          if (opIn) begin
            if (io_vld[chIn]) begin
              dsp_pop  = 1'b1;
              req_in_d = NUMIN'(1) << chIn;
              ula_op_d = 4'd1;
            end else begin
              state_d = ST_WAIT_IN;
            end
          end
          if (opDiv && DIVLAT > 1) begin
            state_d = ST_WAIT_ALU;
            cnt_d   = CW'(DIVLAT - 2);
          end
        end
      end
      ST_WAIT_IN: begin
        if (io_vld[ch_q]) begin
          dsp_pop  = 1'b1;
          req_in_d = NUMIN'(1) << ch_q;
          ula_op_d = 4'd1;
          state_d  = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      ST_WAIT_ALU: begin
        // The divider keeps its opcode until the final busy cycle has passed
        stall    = 1'b1;
        ula_op_d = ula_op_q;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      dsp_pop = 1'b0;
      stall   = 1'b0;
    end
  end

  always_comb begin
    inData = io_in[NBDATA-1:0];
    for (int k = 0; k < NUMIN; k++)
      if (ch_q == CIW'(k)) inData = io_in[k*NBDATA +: NBDATA];
    ula_data = (|req_in_q) ? inData : mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      ula_op_q <= 4'd0;
      req_in_q <= '0;
      out_en_q <= '0;
      srf_q    <= 1'b0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ula_op_q <= ula_op_d;
      req_in_q <= req_in_d;
      out_en_q <= out_en_d;
      srf_q    <= srf_d;
      ch_q     <= ch_d;
    end
  end

`ifdef DEC_ILLEGAL_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk) begin
    if (rst)                      ill_q <= 1'b0;
    else if (accept && !opLegal)  ill_q <= 1'b1;
  end

  assign ill_op = ill_q;
`endif

  assign ula_op   = ula_op_q;
  assign req_in   = req_in_q;
  assign out_en   = out_en_q;
  assign srf      = srf_q;
  assign mem_addr = operand[MDATAW-1:0];

endmodule

// File: tb/tb_instr_dec_mc.sv
// Testbench for instr_dec_mc: decode table, multi-cycle corner cases and a randomized
// run against an abstract reference model.
module tb_instr_dec_mc;

  localparam int NBDATA = 32;
  localparam int NBOPCO = 6;
  localparam int NBOPER = 9;
  localparam int MDATAW = 8;
  localparam int NUMIN  = 2;
  localparam int NUMOUT = 2;
  localparam int DIVLAT = 4;
  localparam int CIW    = (NUMIN > 1) ? $clog2(NUMIN) : 1;
  localparam int COW    = (NUMOUT > 1) ? $clog2(NUMOUT) : 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic [NBOPCO-1:0]       opcode = '0;
  logic [NBOPER-1:0]       operand = '0;
  logic                    stall, dsp_push, dsp_pop, mem_wr, srf, neg;
  logic [3:0]              ula_op;
  logic [NBDATA-1:0]       ula_data;
  logic [MDATAW-1:0]       mem_addr;
  logic [NBDATA-1:0]       mem_data_in = '0;
  logic [NUMIN*NBDATA-1:0] io_in = '0;
  logic [NUMIN-1:0]        io_vld = '0;
  logic [NUMIN-1:0]        req_in;
  logic [NUMOUT-1:0]       out_en;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic                    ill_op;
`endif

  int checks = 0;
  int errors = 0;

  instr_dec_mc #(
    .NBDATA(NBDATA), .NBOPCO(NBOPCO), .NBOPER(NBOPER), .MDATAW(MDATAW),
    .NUMIN(NUMIN), .NUMOUT(NUMOUT), .DIVLAT(DIVLAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .operand(operand),
    .stall(stall), .dsp_push(dsp_push), .dsp_pop(dsp_pop), .ula_op(ula_op),
    .ula_data(ula_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .io_in(io_in), .io_vld(io_vld),
    .req_in(req_in), .out_en(out_en), .srf(srf), .neg(neg)
`ifdef DEC_ILLEGAL_TRAP_EN
    , .ill_op(ill_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [8:0] oper;
    logic [1:0] vld;
    logic       pop, push, wr, ng;
    logic [3:0] ula;
    logic       sr;
    logic [1:0] oe, rq;
  } vec_t;

  vec_t vecs[26];

  // Inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic applyStimulus(input logic r, input logic e, input logic [5:0] op,
                               input logic [8:0] oper, input logic [1:0] vld,
                               input logic [63:0] ioIn = 64'h0,
                               input logic [31:0] mem = 32'h0);
    @(negedge clk);
    rst = r; en = e; opcode = op; operand = oper; io_vld = vld;
    io_in = ioIn; mem_data_in = mem;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] ulaOf(input int op);
    if (op == 0 || op == 1 || op == 3) return 4'd1;
    if (op >= 14 && op <= 21) return 4'((op - 14) / 2 + 2);
    if (op >= 22 && op <= 25) return 4'd10;
    if (op >= 26 && op <= 29) return 4'd12;
    if (op == 30 || op == 31) return 4'd11;
    if (op == 36) return 4'd9;
    if (op >= 38 && op <= 43) return 4'(15 - (op - 38) / 2);
    if (op == 44 || op == 45) return 4'd7;
    if (op == 46 || op == 47) return 4'd6;
    if (op == 48 || op == 49) return 4'd8;
    return 4'd0;
  endfunction

  function automatic bit isListed(input int op);
    return op <= 4 || (op >= 9 && op <= 11) || (op >= 14 && op <= 31) ||
           op == 36 || (op >= 38 && op <= 51);
  endfunction

  // Reference model state
  int         divLeft, waitCh, opI, chI, oI, ulaIdx;
  logic [3:0] mUla, nUla;
  logic       mSrf, nSrf, mIll, nIll;
  logic [1:0] mReq, nReq, mOut, nOut;
  logic       ePop, ePush, eWr, eNeg, eStall;
  logic [31:0] eData;
  logic       rr, ee;
  logic [5:0] oo;
  logic [8:0] pp;
  logic [1:0] vv;
  logic [63:0] io;
  logic [31:0] mm;
  int         favOps[8] = '{10, 10, 11, 18, 19, 21, 9, 51};

  initial begin
    vecs[0]  = '{6'd0,  9'h005, 2'b00, 0, 0, 0, 0, 4'd1,  0, 2'b00, 2'b00};
    vecs[1]  = '{6'd1,  9'h010, 2'b00, 0, 1, 1, 0, 4'd1,  0, 2'b00, 2'b00};
    vecs[2]  = '{6'd2,  9'h011, 2'b00, 0, 0, 1, 0, 4'd0,  0, 2'b00, 2'b00};
    vecs[3]  = '{6'd3,  9'h012, 2'b00, 1, 0, 1, 0, 4'd1,  0, 2'b00, 2'b00};
    vecs[4]  = '{6'd4,  9'h013, 2'b00, 0, 1, 1, 0, 4'd0,  0, 2'b00, 2'b00};
    vecs[5]  = '{6'd9,  9'h000, 2'b00, 1, 0, 0, 0, 4'd0,  1, 2'b00, 2'b00};
    vecs[6]  = '{6'd11, 9'h000, 2'b00, 1, 0, 0, 0, 4'd0,  0, 2'b01, 2'b00};
    vecs[7]  = '{6'd14, 9'h020, 2'b00, 0, 0, 0, 0, 4'd2,  0, 2'b00, 2'b00};
    vecs[8]  = '{6'd15, 9'h021, 2'b00, 1, 0, 0, 0, 4'd2,  0, 2'b00, 2'b00};
    vecs[9]  = '{6'd17, 9'h022, 2'b00, 1, 0, 0, 0, 4'd3,  0, 2'b00, 2'b00};
    vecs[10] = '{6'd22, 9'h023, 2'b00, 0, 0, 0, 0, 4'd10, 0, 2'b00, 2'b00};
    vecs[11] = '{6'd29, 9'h024, 2'b00, 1, 0, 0, 0, 4'd12, 0, 2'b00, 2'b00};
    vecs[12] = '{6'd36, 9'h025, 2'b00, 0, 0, 0, 0, 4'd9,  0, 2'b00, 2'b00};
    vecs[13] = '{6'd35, 9'h026, 2'b00, 0, 0, 0, 0, 4'd0,  0, 2'b00, 2'b00};
    vecs[14] = '{6'd39, 9'h027, 2'b00, 1, 0, 0, 0, 4'd15, 0, 2'b00, 2'b00};
    vecs[15] = '{6'd40, 9'h028, 2'b00, 0, 0, 0, 0, 4'd14, 0, 2'b00, 2'b00};
    vecs[16] = '{6'd43, 9'h029, 2'b00, 1, 0, 0, 0, 4'd13, 0, 2'b00, 2'b00};
    vecs[17] = '{6'd44, 9'h02A, 2'b00, 0, 0, 0, 0, 4'd7,  0, 2'b00, 2'b00};
    vecs[18] = '{6'd47, 9'h02B, 2'b00, 1, 0, 0, 0, 4'd6,  0, 2'b00, 2'b00};
    vecs[19] = '{6'd49, 9'h02C, 2'b00, 1, 0, 0, 0, 4'd8,  0, 2'b00, 2'b00};
    vecs[20] = '{6'd50, 9'h02D, 2'b00, 0, 0, 1, 1, 4'd0,  0, 2'b00, 2'b00};
    vecs[21] = '{6'd51, 9'h1A5, 2'b00, 1, 0, 1, 1, 4'd0,  0, 2'b00, 2'b00};
    vecs[22] = '{6'd12, 9'h02E, 2'b00, 0, 0, 0, 0, 4'd0,  0, 2'b00, 2'b00};
    vecs[23] = '{6'd10, 9'h001, 2'b10, 1, 0, 0, 0, 4'd1,  0, 2'b00, 2'b10};
    vecs[24] = '{6'd30, 9'h02F, 2'b00, 0, 0, 0, 0, 4'd11, 0, 2'b00, 2'b00};
    vecs[25] = '{6'd33, 9'h030, 2'b00, 0, 0, 0, 0, 4'd0,  0, 2'b00, 2'b00};

    // Reset: comb controls masked even with a valid instruction present
    applyStimulus(1, 1, 6'd1, 9'h000, 2'b11);
    checkOutput("rst_push", dsp_push, 0);
    checkOutput("rst_wr", mem_wr, 0);
    checkOutput("rst_pop", dsp_pop, 0);
    checkOutput("rst_stall", stall, 0);
    applyStimulus(1, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("rst_ula", ula_op, 0);
    checkOutput("rst_req", req_in, 0);
    checkOutput("rst_out", out_en, 0);
    checkOutput("rst_srf", srf, 0);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(0, 1, vecs[i].op, vecs[i].oper, vecs[i].vld);
      checkOutput($sformatf("tbl%0d_pop", i), dsp_pop, vecs[i].pop);
      checkOutput($sformatf("tbl%0d_push", i), dsp_push, vecs[i].push);
      checkOutput($sformatf("tbl%0d_wr", i), mem_wr, vecs[i].wr);
      checkOutput($sformatf("tbl%0d_neg", i), neg, vecs[i].ng);
      checkOutput($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].oper[7:0]);
      checkOutput($sformatf("tbl%0d_stall", i), stall, 0);
      applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
      checkOutput($sformatf("tbl%0d_ula", i), ula_op, vecs[i].ula);
      checkOutput($sformatf("tbl%0d_srf", i), srf, vecs[i].sr);
      checkOutput($sformatf("tbl%0d_out", i), out_en, vecs[i].oe);
      checkOutput($sformatf("tbl%0d_req", i), req_in, vecs[i].rq);
    end

    // IN with data already valid on channel 1
    applyStimulus(0, 1, 6'd10, 9'h001, 2'b10, {32'hCAFE0001, 32'h11111111}, 32'h55555555);
    checkOutput("inv_pop", dsp_pop, 1);
    checkOutput("inv_stall", stall, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00, {32'hCAFE0001, 32'h11111111}, 32'h55555555);
    checkOutput("inv_req", req_in, 2'b10);
    checkOutput("inv_ula", ula_op, 1);
    checkOutput("inv_data", ula_data, 32'hCAFE0001);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00, {32'hCAFE0001, 32'h11111111}, 32'h55555555);
    checkOutput("inv_req_end", req_in, 0);
    checkOutput("inv_memdata", ula_data, 32'h55555555);

    // IN waiting three cycles on channel 0
    applyStimulus(0, 1, 6'd10, 9'h000, 2'b00);
    checkOutput("inw_acc_pop", dsp_pop, 0);
    checkOutput("inw_acc_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 6'd10, 9'h000, 2'b00);
      checkOutput($sformatf("inw%0d_stall", i), stall, 1);
      checkOutput($sformatf("inw%0d_pop", i), dsp_pop, 0);
      checkOutput($sformatf("inw%0d_req", i), req_in, 0);
    end
    applyStimulus(0, 1, 6'd10, 9'h000, 2'b01, {32'h0, 32'h0BADF00D});
    checkOutput("inw_rel_pop", dsp_pop, 1);
    checkOutput("inw_rel_stall", stall, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b01, {32'h0, 32'h0BADF00D});
    checkOutput("inw_req", req_in, 2'b01);
    checkOutput("inw_ula", ula_op, 1);
    checkOutput("inw_data", ula_data, 32'h0BADF00D);
    checkOutput("inw_pop_after", dsp_pop, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("inw_req_end", req_in, 0);

    // SDIV occupies the ALU for DIVLAT cycles
    applyStimulus(0, 1, 6'd19, 9'h000, 2'b00);
    checkOutput("sdiv_acc_pop", dsp_pop, 1);
    checkOutput("sdiv_acc_stall", stall, 0);
    for (int i = 0; i < DIVLAT - 1; i++) begin
      applyStimulus(0, 1, 6'd19, 9'h000, 2'b00);
      checkOutput($sformatf("sdiv%0d_stall", i), stall, 1);
      checkOutput($sformatf("sdiv%0d_pop", i), dsp_pop, 0);
      checkOutput($sformatf("sdiv%0d_ula", i), ula_op, 4);
    end
    applyStimulus(0, 1, 6'd14, 9'h000, 2'b00);
    checkOutput("sdiv_last_stall", stall, 0);
    checkOutput("sdiv_last_ula", ula_op, 4);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("sdiv_next_ula", ula_op, 2);
    checkOutput("sdiv_next_stall", stall, 0);

    // Reset in the middle of a divide
    applyStimulus(0, 1, 6'd18, 9'h000, 2'b00);
    checkOutput("rdiv_pop", dsp_pop, 0);
    applyStimulus(0, 1, 6'd18, 9'h000, 2'b00);
    checkOutput("rdiv_stall", stall, 1);
    applyStimulus(1, 1, 6'd18, 9'h000, 2'b00);
    checkOutput("rdiv_rst_pop", dsp_pop, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("rdiv_after_stall", stall, 0);
    checkOutput("rdiv_after_ula", ula_op, 0);
    checkOutput("rdiv_after_pop", dsp_pop, 0);

    // PSETP then OUT to channel 1
    applyStimulus(0, 1, 6'd51, 9'h1A5, 2'b00);
    checkOutput("psetp_wr", mem_wr, 1);
    checkOutput("psetp_pop", dsp_pop, 1);
    checkOutput("psetp_neg", neg, 1);
    checkOutput("psetp_addr", mem_addr, 8'hA5);
    applyStimulus(0, 1, 6'd11, 9'h001, 2'b00);
    checkOutput("out_pop", dsp_pop, 1);
    checkOutput("out_early", out_en, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("out_en", out_en, 2'b10);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("out_en_end", out_en, 0);

`ifdef DEC_ILLEGAL_TRAP_EN
    applyStimulus(1, 0, 6'd0, 9'h000, 2'b00);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("trap_clear", ill_op, 0);
    applyStimulus(0, 1, 6'd60, 9'h1FF, 2'b11);
    checkOutput("trap_pop", dsp_pop, 0);
    checkOutput("trap_wr", mem_wr, 0);
    checkOutput("trap_push", dsp_push, 0);
    applyStimulus(0, 1, 6'd0, 9'h000, 2'b00);
    checkOutput("trap_set", ill_op, 1);
    checkOutput("trap_ula", ula_op, 0);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("trap_hold", ill_op, 1);
    applyStimulus(1, 0, 6'd0, 9'h000, 2'b00);
    applyStimulus(0, 0, 6'd0, 9'h000, 2'b00);
    checkOutput("trap_rst", ill_op, 0);
`endif

    // Randomized run against the abstract model, starting from a fresh reset
    applyStimulus(1, 0, 6'd0, 9'h000, 2'b00);
    divLeft = 0; waitCh = -1;
    mUla = 0; mSrf = 0; mReq = 0; mOut = 0; mIll = 0;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 79) == 0);
      ee = ($urandom_range(0, 3) != 0);
      oo = ($urandom_range(0, 1) == 1) ? 6'(favOps[$urandom_range(0, 7)]) : 6'($urandom_range(0, 63));
      pp = 9'($urandom);
      vv = 2'($urandom);
      io = {$urandom, $urandom};
      mm = $urandom;
      applyStimulus(rr, ee, oo, pp, vv, io, mm);

      ePop = 0; ePush = 0; eWr = 0; eNeg = 0; eStall = 0;
      nUla = 0; nSrf = 0; nReq = 0; nOut = 0; nIll = mIll;
      ulaIdx = -1;
      for (int k = 0; k < NUMIN; k++) if (mReq[k]) ulaIdx = k;
      eData = (ulaIdx >= 0) ? io[ulaIdx*32 +: 32] : mm;

      if (rr) begin
        divLeft = 0; waitCh = -1; nIll = 0;
      end else if (waitCh >= 0) begin
        if (vv[waitCh]) begin
          ePop = 1; nReq = 2'(1 << waitCh); nUla = 1; waitCh = -1;
        end else eStall = 1;
      end else if (divLeft > 0) begin
        eStall = 1; nUla = mUla; divLeft--;
      end else if (ee) begin
        opI = int'(oo);
        chI = int'(pp) % (1 << CIW);
        oI  = int'(pp) % (1 << COW);
        if (opI == 10) begin
          if (chI >= NUMIN) nIll = 1;
          else if (vv[chI]) begin ePop = 1; nReq = 2'(1 << chI); nUla = 1; end
          else waitCh = chI;
        end else if (opI == 11) begin
          if (oI >= NUMOUT) nIll = 1;
          else begin ePop = 1; nOut = 2'(1 << oI); end
        end else if (isListed(opI)) begin
          eWr   = (opI >= 1 && opI <= 4) || opI >= 50;
          ePush = (opI == 1 || opI == 4);
          eNeg  = (opI >= 50);
          ePop  = opI == 3 || opI == 9 || opI == 51 ||
                  (opI % 2 == 1 && opI >= 15 && opI <= 49 && (opI < 33 || opI > 37));
          nSrf  = (opI == 9);
          nUla  = ulaOf(opI);
          if (opI >= 18 && opI <= 21) divLeft = DIVLAT - 1;
        end else nIll = 1;
      end

      checkOutput("rnd_pop", dsp_pop, ePop);
      checkOutput("rnd_push", dsp_push, ePush);
      checkOutput("rnd_wr", mem_wr, eWr);
      checkOutput("rnd_neg", neg, eNeg);
      checkOutput("rnd_stall", stall, eStall);
      checkOutput("rnd_addr", mem_addr, pp[7:0]);
      checkOutput("rnd_ula", ula_op, mUla);
      checkOutput("rnd_srf", srf, mSrf);
      checkOutput("rnd_req", req_in, mReq);
      checkOutput("rnd_out", out_en, mOut);
      checkOutput("rnd_data", ula_data, eData);
`ifdef DEC_ILLEGAL_TRAP_EN
      checkOutput("rnd_ill", ill_op, mIll);
`endif
      mUla = nUla; mSrf = nSrf; mReq = nReq; mOut = nOut; mIll = nIll;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
